// File: rtl/rr_grant_encoder.sv
// rtl/rr_grant_encoder.sv - 4-way round-robin arbiter with registered binary grant index
// Optional forced release after HOLD_MAX cycles: define RR_GRANT_TIMEOUT_EN.
module rr_grant_encoder #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic       found;
    logic [1:0] win;
    logic       release_req;

    if (HOLD_MAX < 2 || HOLD_MAX > 15 || (2 ** CNT_W) <= HOLD_MAX) begin : g_bad_params
        $error("rr_grant_encoder: HOLD_MAX must be 2..15 and fit below 2**CNT_W");
    end

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr + 2'(i)]) begin
                found = 1'b1;
                win   = ptr + 2'(i);
            end
        end
    end

    assign release_req = done || !req[grant_idx];

`ifdef RR_GRANT_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    logic [CNT_W-1:0] hold_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 2'b00;
            grant_idx   <= 2'b00;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (found) begin
                        grant_idx   <= win;
                        grant_valid <= 1'b1;
                        hold_cnt    <= '0;
                        state       <= HOLD;
                    end else begin
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                HOLD: begin
                    // A genuine release takes precedence, so timeout stays low then.
                    if (release_req) begin
                        grant_valid <= 1'b0;
                        ptr         <= grant_idx + 2'd1;
                        state       <= GAP;
                    end else if (hold_cnt == HOLD_LAST) begin
                        grant_valid <= 1'b0;
                        ptr         <= grant_idx + 2'd1;
                        state       <= GAP;
                        timeout     <= 1'b1;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    grant_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
`else
    assign timeout = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 2'b00;
            grant_idx   <= 2'b00;
            grant_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    if (found) begin
                        grant_idx   <= win;
                        grant_valid <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                HOLD: begin
                    if (release_req) begin
                        grant_valid <= 1'b0;
                        ptr         <= grant_idx + 2'd1;
                        state       <= GAP;
                    end
                end
                default: begin
                    grant_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_rr_grant_encoder.sv
// tb/tb_rr_grant_encoder.sv - directed bench for rr_grant_encoder
module tb_rr_grant_encoder;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int vectors;
    int miscompares;

    rr_grant_encoder #(.HOLD_MAX(8), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_valid", {3'b0, grant_valid}, 4'h0);
        chk("reset_idx", {2'b0, grant_idx}, 4'h0);
        chk("reset_timeout", {3'b0, timeout}, 4'h0);

        // Single request, release with done, re-grant after one gap cycle
        req = 4'b0100;
        tick();
        chk("single_grant", {1'b0, grant_valid, grant_idx}, 4'b0110);
        tick();
        tick();
        chk("single_hold", {1'b0, grant_valid, grant_idx}, 4'b0110);
        done = 1'b1;
        tick();
        chk("single_release", {1'b0, grant_valid, grant_idx}, 4'b0010);
        done = 1'b0;
        tick();
        chk("single_regrant", {1'b0, grant_valid, grant_idx}, 4'b0110);

        // Asynchronous reset mid-HOLD
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b1111;
        tick();
        chk("pre_reset_grant", {1'b0, grant_valid, grant_idx}, 4'b0111);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", {timeout, grant_valid, grant_idx}, 4'b0000);
        rst = 1'b0;
        tick();
        chk("rot_first", {1'b0, grant_valid, grant_idx}, 4'b0100);

        // Rotation 00 -> 01 -> 10 -> 11 -> 00 with one low cycle between grants
        for (int k = 1; k <= 4; k++) begin
            done = 1'b1;
            tick();
            chk("rot_gap", {1'b0, grant_valid, grant_idx}, {2'b00, 2'(k - 1)});
            done = 1'b0;
            tick();
            chk("rot_grant", {1'b0, grant_valid, grant_idx}, {2'b01, 2'(k)});
        end

        // Wrap: holding 00; move to 11, then 1001 wraps to 00, then back to 11
        req  = 4'b1000;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk("wrap_grant3", {1'b0, grant_valid, grant_idx}, 4'b0111);
        req  = 4'b1001;
        done = 1'b1;
        tick();
        chk("wrap_gap", {1'b0, grant_valid, grant_idx}, 4'b0011);
        done = 1'b0;
        tick();
        chk("wrap_grant0", {1'b0, grant_valid, grant_idx}, 4'b0100);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk("wrap_grant3b", {1'b0, grant_valid, grant_idx}, 4'b0111);

        // Request drop on idx 01; other bits ignored while holding
        req  = 4'b0010;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk("drop_grant1", {1'b0, grant_valid, grant_idx}, 4'b0101);
        req = 4'b1010;
        tick();
        chk("drop_ignore_req3", {1'b0, grant_valid, grant_idx}, 4'b0101);
        req = 4'b0010;
        tick();
        chk("drop_ignore_req3b", {1'b0, grant_valid, grant_idx}, 4'b0101);
        req = 4'b0101;
        tick();
        chk("drop_release", {1'b0, grant_valid, grant_idx}, 4'b0001);
        tick();
        chk("drop_ptr2", {1'b0, grant_valid, grant_idx}, 4'b0110);

        // Long hold on requester 0
        req = 4'b0001;
        tick();
        chk("hold_gap", {1'b0, grant_valid, grant_idx}, 4'b0010);
        tick();
        chk("hold_grant0", {timeout, grant_valid, grant_idx}, 4'b0100);
`ifdef RR_GRANT_TIMEOUT_EN
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("to_holding", {timeout, grant_valid, grant_idx}, 4'b0100);
        end
        tick();
        chk("to_pulse", {timeout, grant_valid, grant_idx}, 4'b1000);
        tick();
        chk("to_regrant", {timeout, grant_valid, grant_idx}, 4'b0100);
        done = 1'b1;
        tick();
        chk("to_done_release", {timeout, grant_valid, grant_idx}, 4'b0000);
        done = 1'b0;
`else
        for (int k = 1; k <= 55; k++) begin
            tick();
            chk("no_timeout_hold", {timeout, grant_valid, grant_idx}, 4'b0100);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
